// File: rtl/multi_channel_adc_scanner_if.sv
// Bus between the ADC scanner and its environment: sampled channel voltages,
// scan control and the result bank with its strobes.
interface multi_channel_adc_scanner_if #(
  parameter int unsigned NUM_CHANNELS = 3,
  parameter int unsigned RESOLUTION   = 10
);
  logic [16*NUM_CHANNELS-1:0]         voltage_mv;
  logic                               sensor_enable;
  logic                               start;
  logic                               continuous;
  logic [RESOLUTION*NUM_CHANNELS-1:0] digital_out;
  logic                               ch_valid;
  logic [3:0]                         ch_index;
  logic                               scan_done;
  logic                               busy;

  // Environment side: drives voltages and scan control, observes results
  modport master (
    output voltage_mv, sensor_enable, start, continuous,
    input  digital_out, ch_valid, ch_index, scan_done, busy
  );

  // Scanner side
  modport slave (
    input  voltage_mv, sensor_enable, start, continuous,
    output digital_out, ch_valid, ch_index, scan_done, busy
  );
endinterface

// File: rtl/multi_channel_adc_scanner.sv
// multi_channel_adc_scanner: round-robin millivolt-to-code scanner.
// Each sample is scaled by (2^RESOLUTION-1) and divided by VREF_MV with a
// shared restoring divider (one quotient bit per cycle); 2^AVG_LOG2
// conversions per channel are averaged into a per-channel result bank.
// Optional feature macro: ADC_CLAMP_EN -- saturate inputs >= VREF_MV to full
// scale instead of letting the quotient wrap.
module multi_channel_adc_scanner #(
  parameter int unsigned NUM_CHANNELS = 3,
  parameter int unsigned RESOLUTION   = 10,
  parameter int unsigned VREF_MV      = 5000,
  parameter int unsigned AVG_LOG2     = 0
) (
  input  logic                       clk,
  input  logic                       reset_n,
  multi_channel_adc_scanner_if.slave bus
);

  localparam int unsigned W         = 16 + RESOLUTION;
  localparam int unsigned BIT_CNT_W = $clog2(W);
  localparam int unsigned CONV_W    = AVG_LOG2 + 1;
  localparam int unsigned CONV_LAST = (1 << AVG_LOG2) - 1;
  localparam int unsigned ACC_W     = RESOLUTION + AVG_LOG2;
  localparam int unsigned MAX_CODE  = (1 << RESOLUTION) - 1;
  localparam int unsigned LAST_CH   = NUM_CHANNELS - 1;
  localparam int unsigned DOUT_W    = RESOLUTION * NUM_CHANNELS;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_DIVIDE,
    S_ACCUM,
    S_STORE
  } state_t;

  state_t                 r_state;
  state_t                 w_next_state;

  logic [3:0]             r_ch;
  logic [CONV_W-1:0]      r_conv;
  logic [BIT_CNT_W-1:0]   r_bit_cnt;
  logic [W-1:0]           r_dividend;
  logic [15:0]            r_rem;
  logic [ACC_W-1:0]       r_acc;
  logic [DOUT_W-1:0]      r_digital_out;
  logic                   r_ch_valid;
  logic [3:0]             r_ch_index;
  logic                   r_scan_done;
  logic                   r_busy;
`ifdef ADC_CLAMP_EN
  logic                   r_over;
`endif

  logic                   w_abort;
  logic                   w_div_last;
  logic                   w_conv_last;
  logic                   w_ch_last;
  logic [15:0]            w_v_sel;
  logic [16:0]            w_rem_shift;
  logic                   w_rem_ge;
  logic [15:0]            w_rem_next;
  logic [RESOLUTION-1:0]  w_conv_result;
  logic [RESOLUTION-1:0]  w_avg;

  // Datapath helpers: channel mux, one divider step, result formatting
  always_comb begin
    w_abort     = (r_state != S_IDLE) && !bus.sensor_enable;
    w_div_last  = (r_bit_cnt == BIT_CNT_W'(W - 1));
    w_conv_last = (r_conv == CONV_W'(CONV_LAST));
    w_ch_last   = (r_ch == 4'(LAST_CH));

    w_v_sel = 16'd0;
    for (int k = 0; k < int'(NUM_CHANNELS); k++) begin
      if (r_ch == 4'(k)) begin
        w_v_sel = bus.voltage_mv[16*k +: 16];
      end
    end

    w_rem_shift = {r_rem, r_dividend[W-1]};
    w_rem_ge    = (w_rem_shift >= 17'(VREF_MV));
    w_rem_next  = w_rem_ge ? 16'(w_rem_shift - 17'(VREF_MV)) : w_rem_shift[15:0];

`ifdef ADC_CLAMP_EN
    w_conv_result = r_over ? RESOLUTION'(MAX_CODE) : r_dividend[RESOLUTION-1:0];
`else
    w_conv_result = r_dividend[RESOLUTION-1:0];
`endif

    w_avg = RESOLUTION'(r_acc >> AVG_LOG2);
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic; a dropped enable overrides every transition
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.start && bus.sensor_enable) begin
          w_next_state = S_LOAD;
        end
      end
      S_LOAD: begin
        w_next_state = S_DIVIDE;
      end
      S_DIVIDE: begin
        if (w_div_last) begin
          w_next_state = S_ACCUM;
        end
      end
      S_ACCUM: begin
        w_next_state = w_conv_last ? S_STORE : S_LOAD;
      end
      S_STORE: begin
        if (!w_ch_last || bus.continuous) begin
          w_next_state = S_LOAD;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
    if (w_abort) begin
      w_next_state = S_IDLE;
    end
  end

  // Conversion datapath: latch, divide, accumulate, channel sequencing
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ch       <= 4'd0;
      r_conv     <= '0;
      r_bit_cnt  <= '0;
      r_dividend <= '0;
      r_rem      <= 16'd0;
      r_acc      <= '0;
`ifdef ADC_CLAMP_EN
      r_over     <= 1'b0;
`endif
    end else if (w_abort) begin
      r_ch      <= 4'd0;
      r_conv    <= '0;
      r_bit_cnt <= '0;
      r_acc     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start && bus.sensor_enable) begin
            r_ch   <= 4'd0;
            r_conv <= '0;
            r_acc  <= '0;
          end
        end
        S_LOAD: begin
          r_dividend <= W'(w_v_sel) * W'(MAX_CODE);
          r_rem      <= 16'd0;
          r_bit_cnt  <= '0;
`ifdef ADC_CLAMP_EN
          r_over     <= (32'(w_v_sel) >= VREF_MV);
`endif
        end
        S_DIVIDE: begin
          r_rem      <= w_rem_next;
          r_dividend <= {r_dividend[W-2:0], w_rem_ge};
          r_bit_cnt  <= r_bit_cnt + BIT_CNT_W'(1);
        end
        S_ACCUM: begin
          r_acc  <= r_acc + ACC_W'(w_conv_result);
          r_conv <= w_conv_last ? CONV_W'(0) : r_conv + CONV_W'(1);
        end
        S_STORE: begin
          r_acc <= '0;
          r_ch  <= w_ch_last ? 4'd0 : r_ch + 4'd1;
        end
        default: begin
          r_acc <= '0;
        end
      endcase
    end
  end

  // Registered outputs: result bank write and strobes in STORE, busy flag
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_digital_out <= '0;
      r_ch_valid    <= 1'b0;
      r_ch_index    <= 4'd0;
      r_scan_done   <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_ch_valid  <= 1'b0;
      r_scan_done <= 1'b0;
      r_busy      <= (r_state != S_IDLE);
      if ((r_state == S_STORE) && !w_abort) begin
        for (int k = 0; k < int'(NUM_CHANNELS); k++) begin
          if (r_ch == 4'(k)) begin
            r_digital_out[k*RESOLUTION +: RESOLUTION] <= w_avg;
          end
        end
        r_ch_valid  <= 1'b1;
        r_ch_index  <= r_ch;
        r_scan_done <= w_ch_last;
      end
    end
  end

  assign bus.digital_out = r_digital_out;
  assign bus.ch_valid    = r_ch_valid;
  assign bus.ch_index    = r_ch_index;
  assign bus.scan_done   = r_scan_done;
  assign bus.busy        = r_busy;

endmodule

// File: tb/tb_multi_channel_adc_scanner.sv
// Scoreboard bench for multi_channel_adc_scanner: stimulus pushes expected
// channel results with their arrival cycle; per-DUT monitors pop and compare
// on every ch_valid. A second instance exercises averaging (AVG_LOG2=2).
module tb_multi_channel_adc_scanner;

  typedef struct {
    int t;
    int idx;
    int val;
    int done;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n;
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;
  exp_t q_main[$];
  exp_t q_avg[$];

  multi_channel_adc_scanner_if #(.NUM_CHANNELS(3), .RESOLUTION(10)) bus_m ();
  multi_channel_adc_scanner_if #(.NUM_CHANNELS(1), .RESOLUTION(10)) bus_a ();

  multi_channel_adc_scanner #(
    .NUM_CHANNELS(3), .RESOLUTION(10), .VREF_MV(5000), .AVG_LOG2(0)
  ) u_dut (
    .clk(clk), .reset_n(reset_n), .bus(bus_m)
  );

  multi_channel_adc_scanner #(
    .NUM_CHANNELS(1), .RESOLUTION(10), .VREF_MV(5000), .AVG_LOG2(2)
  ) u_avg (
    .clk(clk), .reset_n(reset_n), .bus(bus_a)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int slot(input logic [29:0] d, input int k);
    logic [29:0] s;
    s = d >> (k * 10);
    return int'(s[9:0]);
  endfunction

  task automatic wait_to(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  // Monitor for the 3-channel instance
  always @(negedge clk) begin
    exp_t e;
    if (bus_m.ch_valid) begin
      total++;
      if (q_main.size() == 0) begin
        bad++;
        $display("FAIL main_unexpected_ch_valid: got ch %0d, expected none (cycle %0d)",
                 bus_m.ch_index, cyc);
      end else begin
        e = q_main.pop_front();
        chk("main_ch_time", cyc, e.t);
        chk("main_ch_index", bus_m.ch_index, e.idx);
        chk("main_slot_value", slot(bus_m.digital_out, e.idx), e.val);
        chk("main_scan_done", bus_m.scan_done, e.done);
      end
    end else if (bus_m.scan_done) begin
      total++;
      bad++;
      $display("FAIL main_stray_scan_done: got 1 expected 0 (cycle %0d)", cyc);
    end
  end

  // Monitor for the averaging instance
  always @(negedge clk) begin
    exp_t e;
    if (bus_a.ch_valid) begin
      total++;
      if (q_avg.size() == 0) begin
        bad++;
        $display("FAIL avg_unexpected_ch_valid: got 1 expected 0 (cycle %0d)", cyc);
      end else begin
        e = q_avg.pop_front();
        chk("avg_ch_time", cyc, e.t);
        chk("avg_ch_index", bus_a.ch_index, e.idx);
        chk("avg_slot_value", bus_a.digital_out, e.val);
        chk("avg_scan_done", bus_a.scan_done, e.done);
      end
    end
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1, "watchdog expired");
  end

  // Directed stimulus
  initial begin
    int t0;
    int over_exp;

`ifdef ADC_CLAMP_EN
    over_exp = 1023;
`else
    over_exp = 203;
`endif

    // Reset with arbitrary live inputs
    reset_n             = 1'b0;
    bus_m.voltage_mv    = {16'($urandom), 16'($urandom), 16'($urandom)};
    bus_m.sensor_enable = 1'b1;
    bus_m.start         = 1'b1;
    bus_m.continuous    = 1'b1;
    bus_a.voltage_mv    = 16'($urandom);
    bus_a.sensor_enable = 1'b1;
    bus_a.start         = 1'b1;
    bus_a.continuous    = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_digital_out", bus_m.digital_out, 0);
    chk("rst_ch_valid", bus_m.ch_valid, 0);
    chk("rst_ch_index", bus_m.ch_index, 0);
    chk("rst_scan_done", bus_m.scan_done, 0);
    chk("rst_busy", bus_m.busy, 0);
    chk("rst_avg_busy", bus_a.busy, 0);

    bus_m.start         = 1'b0;
    bus_m.continuous    = 1'b0;
    bus_a.start         = 1'b0;
    bus_a.sensor_enable = 1'b0;
    reset_n             = 1'b1;
    t0 = cyc;
    wait_to(t0 + 50);
    chk("idle_digital_out", bus_m.digital_out, 0);
    chk("idle_busy", bus_m.busy, 0);

    // Single scan: 2500 / 5000 / 0 mV
    bus_m.voltage_mv = {16'd0, 16'd5000, 16'd2500};
    bus_m.start = 1'b1;
    @(posedge clk); #1;
    t0 = cyc;
    bus_m.start = 1'b0;
    q_main.push_back('{t0 + 29, 0, 511, 0});
    q_main.push_back('{t0 + 58, 1, 1023, 0});
    q_main.push_back('{t0 + 87, 2, 0, 1});
    wait_to(t0 + 5);
    bus_m.voltage_mv[15:0] = 16'd4000;  // after ch0 was latched
    wait_to(t0 + 10);
    chk("scan_busy_high", bus_m.busy, 1);
    wait_to(t0 + 88);
    chk("scan_busy_low", bus_m.busy, 0);
    chk("scan_slot0", slot(bus_m.digital_out, 0), 511);
    chk("scan_slot1", slot(bus_m.digital_out, 1), 1023);
    chk("scan_slot2", slot(bus_m.digital_out, 2), 0);

    // Abort during channel 1, with an ignored mid-scan start
    wait_to(t0 + 95);
    bus_m.voltage_mv = {16'd0, 16'd1000, 16'd4000};
    bus_m.start = 1'b1;
    @(posedge clk); #1;
    t0 = cyc;
    bus_m.start = 1'b0;
    q_main.push_back('{t0 + 29, 0, 818, 0});
    wait_to(t0 + 10);
    bus_m.start = 1'b1;
    @(negedge clk);
    bus_m.start = 1'b0;
    wait_to(t0 + 39);
    bus_m.sensor_enable = 1'b0;
    wait_to(t0 + 41);
    chk("abort_busy_low", bus_m.busy, 0);
    wait_to(t0 + 60);
    chk("abort_slot1_kept", slot(bus_m.digital_out, 1), 1023);
    chk("abort_slot0_new", slot(bus_m.digital_out, 0), 818);
    bus_m.sensor_enable = 1'b1;
    wait_to(t0 + 70);
    chk("abort_stays_idle", bus_m.busy, 0);

    // Over-range and near-full-scale
    bus_m.voltage_mv = {16'd4999, 16'd1, 16'd6000};
    bus_m.start = 1'b1;
    @(posedge clk); #1;
    t0 = cyc;
    bus_m.start = 1'b0;
    q_main.push_back('{t0 + 29, 0, over_exp, 0});
    q_main.push_back('{t0 + 58, 1, 0, 0});
    q_main.push_back('{t0 + 87, 2, 1022, 1});
    wait_to(t0 + 92);

    // Continuous: two back-to-back scans, second scan sees a new ch2 value
    bus_m.voltage_mv = {16'd0, 16'd5000, 16'd2500};
    bus_m.continuous = 1'b1;
    bus_m.start = 1'b1;
    @(posedge clk); #1;
    t0 = cyc;
    bus_m.start = 1'b0;
    q_main.push_back('{t0 + 29, 0, 511, 0});
    q_main.push_back('{t0 + 58, 1, 1023, 0});
    q_main.push_back('{t0 + 87, 2, 0, 1});
    q_main.push_back('{t0 + 116, 0, 511, 0});
    q_main.push_back('{t0 + 145, 1, 1023, 0});
    q_main.push_back('{t0 + 174, 2, 1023, 1});
    wait_to(t0 + 88);
    chk("cont_busy_held", bus_m.busy, 1);
    wait_to(t0 + 90);
    bus_m.voltage_mv[47:32] = 16'd5000;
    wait_to(t0 + 100);
    bus_m.continuous = 1'b0;
    wait_to(t0 + 177);
    chk("cont_busy_low", bus_m.busy, 0);

    // Averaging instance: 1000, 1000, 3000, 3000 mV -> floor(1634/4) = 408
    bus_a.voltage_mv    = 16'd1000;
    bus_a.sensor_enable = 1'b1;
    bus_a.start = 1'b1;
    @(posedge clk); #1;
    t0 = cyc;
    bus_a.start = 1'b0;
    q_avg.push_back('{t0 + 113, 0, 408, 1});
    wait_to(t0 + 40);
    bus_a.voltage_mv = 16'd3000;
    wait_to(t0 + 116);
    chk("avg_result_held", bus_a.digital_out, 408);
    chk("avg_busy_low", bus_a.busy, 0);

    wait_to(cyc + 5);
    chk("main_queue_drained", q_main.size(), 0);
    chk("avg_queue_drained", q_avg.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
